// File: rtl/exposure_v1_t7.sv
// Exposure sequencer: global reset, projector trigger, mask row load, exposure,
// drain and GSUB phases per pattern, then a readout trigger handshake per frame.
module exposure_v1_t7 (
  input  logic        CLKM,
  input  logic        rst,
  input  logic        re_busy,
  input  logic [31:0] NUM_PAT,
  input  logic [31:0] NUM_REP,
  input  logic [31:0] NUM_ROW,
  input  logic [31:0] NUM_GSUB,
  input  logic [31:0] Tproj_dly,
  input  logic [31:0] Tgl_res,
  input  logic [31:0] Treset,
  input  logic [31:0] Tadd,
  input  logic [31:0] Texp_ctrl,
  input  logic [31:0] Tdes2_d,
  input  logic [31:0] Tdes2_w,
  input  logic [31:0] Tmsken_d,
  input  logic [31:0] Tmsken_w,
  input  logic [31:0] Tgsub_w,
  input  logic [31:0] TdrainR_d,
  input  logic [31:0] TdrainF_d,
  output logic        trigger_o,
  output logic [7:0]  ROWADD,
  output logic        EN_STREAM,
  output logic        DES_2ND,
  output logic        PROJ_TRG,
  output logic        MASK_EN,
  output logic        PIXGLOB_RES,
  output logic        PIXVTG_GLOB,
  output logic        PIXDRAIN,
  output logic        PIXGSUBC,
  output logic        contrastLED
);

  typedef enum logic [3:0] {
    S_IDLE, S_GRES, S_SETTLE, S_PROJ, S_ROWLD, S_EXP,
    S_DRAIN, S_GSUB, S_TRIG, S_WAIT_HI, S_WAIT_LO
  } state_t;

  typedef struct packed {
    logic [31:0] num_pat;
    logic [31:0] num_rep;
    logic [31:0] num_row;
    logic [31:0] num_gsub;
    logic [31:0] tproj_dly;
    logic [31:0] tgl_res;
    logic [31:0] treset;
    logic [31:0] tadd;
    logic [31:0] texp_ctrl;
    logic [31:0] tdes2_d;
    logic [31:0] tdes2_w;
    logic [31:0] tmsken_d;
    logic [31:0] tmsken_w;
    logic [31:0] tgsub_w;
    logic [31:0] tdrainr_d;
    logic [31:0] tdrainf_d;
  } cfg_t;

  cfg_t        cfg_live, cfg_q;
  state_t      state, nxt;
  logic [31:0] cnt, row, pat, rep, gsub_n;
  logic [31:0] nxt_cnt, nxt_row, nxt_pat, nxt_rep, nxt_gsub;
  logic        frame_start, stage_done, enter;
  logic [33:0] proj_len, slot_len, gsub_period;

  logic        o_trig, o_en_stream, o_des, o_proj, o_mask;
  logic        o_gres, o_vtg, o_drain, o_gsubc, o_led;
  logic [7:0]  o_rowadd;

  assign cfg_live = '{num_pat: NUM_PAT, num_rep: NUM_REP, num_row: NUM_ROW,
                      num_gsub: NUM_GSUB, tproj_dly: Tproj_dly, tgl_res: Tgl_res,
                      treset: Treset, tadd: Tadd, texp_ctrl: Texp_ctrl,
                      tdes2_d: Tdes2_d, tdes2_w: Tdes2_w, tmsken_d: Tmsken_d,
                      tmsken_w: Tmsken_w, tgsub_w: Tgsub_w, tdrainr_d: TdrainR_d,
                      tdrainf_d: TdrainF_d};

  // Phase lengths are widened so sums of full-range durations cannot wrap.
  assign proj_len    = (cfg_q.tproj_dly == '0) ? 34'd1 : {2'b00, cfg_q.tproj_dly};
  assign slot_len    = {2'b00, cfg_q.tadd} + {2'b00, cfg_q.tdes2_d} + {2'b00, cfg_q.tdes2_w};
  assign gsub_period = {1'b0, cfg_q.tgsub_w, 1'b0};

  function automatic logic last_cycle(input logic [31:0] c, input logic [33:0] dur);
    return ({2'b00, c} + 34'd1) >= dur;
  endfunction

  function automatic state_t after_settle(input cfg_t p);
    return (p.num_pat == '0 || p.num_rep == '0) ? S_TRIG : S_PROJ;
  endfunction

  function automatic state_t after_gres(input cfg_t p);
    return (p.treset != '0) ? S_SETTLE : after_settle(p);
  endfunction

  function automatic state_t frame_entry(input cfg_t p);
    return (p.tgl_res != '0) ? S_GRES : after_gres(p);
  endfunction

  // First non-empty pattern stage after 'from'; S_IDLE means the pattern is complete.
  function automatic state_t stage_after(input state_t from, input cfg_t p);
    state_t s;
    logic   rows_on, gsub_on;
    rows_on = (p.num_row != '0) &&
              (p.tadd != '0 || p.tdes2_d != '0 || p.tdes2_w != '0);
    gsub_on = (p.num_gsub != '0) && (p.tgsub_w != '0);
    s = S_IDLE;
    if (from inside {S_PROJ, S_ROWLD, S_EXP, S_DRAIN} && gsub_on) s = S_GSUB;
    if (from inside {S_PROJ, S_ROWLD, S_EXP} && p.tdrainr_d != '0) s = S_DRAIN;
    if (from inside {S_PROJ, S_ROWLD} && p.texp_ctrl != '0)       s = S_EXP;
    if (from == S_PROJ && rows_on)                                  s = S_ROWLD;
    return s;
  endfunction

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    nxt         = state;
    nxt_cnt     = cnt + 32'd1;
    nxt_row     = row;
    nxt_pat     = pat;
    nxt_rep     = rep;
    nxt_gsub    = gsub_n;
    frame_start = 1'b0;
    stage_done  = 1'b0;
    enter       = 1'b0;

    case (state)
      S_IDLE: begin
        nxt_cnt = cnt;
        if (!re_busy) frame_start = 1'b1;
      end
      S_GRES: if (last_cycle(cnt, {2'b00, cfg_q.tgl_res})) begin
        nxt   = after_gres(cfg_q);
        enter = 1'b1;
      end
      S_SETTLE: if (last_cycle(cnt, {2'b00, cfg_q.treset})) begin
        nxt   = after_settle(cfg_q);
        enter = 1'b1;
      end
      S_PROJ: if (last_cycle(cnt, proj_len)) stage_done = 1'b1;
      S_ROWLD: if (last_cycle(cnt, slot_len)) begin
        if (({1'b0, row} + 33'd1) >= {1'b0, cfg_q.num_row}) stage_done = 1'b1;
        else begin
          nxt_row = row + 32'd1;
          nxt_cnt = '0;
        end
      end
      S_EXP:   if (last_cycle(cnt, {2'b00, cfg_q.texp_ctrl})) stage_done = 1'b1;
      S_DRAIN: if (last_cycle(cnt, {2'b00, cfg_q.tdrainr_d})) stage_done = 1'b1;
      S_GSUB: if (last_cycle(cnt, gsub_period)) begin
        if (({1'b0, gsub_n} + 33'd1) >= {1'b0, cfg_q.num_gsub}) stage_done = 1'b1;
        else begin
          nxt_gsub = gsub_n + 32'd1;
          nxt_cnt  = '0;
        end
      end
      S_TRIG: begin
        nxt   = S_WAIT_HI;
        enter = 1'b1;
      end
      S_WAIT_HI: begin
        nxt_cnt = cnt;
        if (re_busy) begin
          nxt   = S_WAIT_LO;
          enter = 1'b1;
        end
      end
      S_WAIT_LO: begin
        nxt_cnt = cnt;
        if (!re_busy) frame_start = 1'b1;
      end
      default: begin
        nxt   = S_IDLE;
        enter = 1'b1;
      end
    endcase

    if (stage_done) begin
      enter = 1'b1;
      nxt   = stage_after(state, cfg_q);
      if (nxt == S_IDLE) begin
        if (({1'b0, pat} + 33'd1) >= {1'b0, cfg_q.num_pat}) begin
          nxt_pat = '0;
          nxt_rep = rep + 32'd1;
          nxt     = (({1'b0, rep} + 33'd1) >= {1'b0, cfg_q.num_rep}) ? S_TRIG : S_PROJ;
        end else begin
          nxt_pat = pat + 32'd1;
          nxt     = S_PROJ;
        end
      end
    end

    // Frame entry resolves skipped phases against the live inputs being latched.
    if (frame_start) begin
      enter   = 1'b1;
      nxt     = frame_entry(cfg_live);
      nxt_pat = '0;
      nxt_rep = '0;
    end

    if (enter) begin
      nxt_cnt  = '0;
      nxt_row  = '0;
      nxt_gsub = '0;
    end
  end

  // Outputs are decoded from the upcoming state so the registers line up with it.
  always_comb begin
    o_trig      = 1'b0;
    o_rowadd    = '0;
    o_en_stream = 1'b0;
    o_des       = 1'b0;
    o_proj      = 1'b0;
    o_mask      = 1'b0;
    o_gres      = 1'b0;
    o_vtg       = 1'b0;
    o_drain     = 1'b1;
    o_gsubc     = 1'b0;
    o_led       = 1'b0;
    case (nxt)
      S_GRES:  o_gres = 1'b1;
      S_PROJ:  o_proj = (nxt_cnt == '0);
      S_ROWLD: begin
        o_rowadd    = nxt_row[7:0];
        o_en_stream = (nxt_cnt == '0);
        o_des       = (nxt_cnt >= cfg_q.tdes2_d) && ((nxt_cnt - cfg_q.tdes2_d) < cfg_q.tdes2_w);
      end
      S_EXP: begin
        o_vtg   = 1'b1;
        o_led   = 1'b1;
        o_mask  = (nxt_cnt >= cfg_q.tmsken_d) && ((nxt_cnt - cfg_q.tmsken_d) < cfg_q.tmsken_w);
        o_drain = (nxt_cnt < cfg_q.tdrainf_d);
      end
      S_DRAIN: o_drain = 1'b0;
      S_GSUB:  o_gsubc = (nxt_cnt < cfg_q.tgsub_w);
      S_TRIG:  o_trig  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLKM or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      row         <= '0;
      pat         <= '0;
      rep         <= '0;
      gsub_n      <= '0;
      cfg_q       <= '0;
      trigger_o   <= 1'b0;
      ROWADD      <= '0;
      EN_STREAM   <= 1'b0;
      DES_2ND     <= 1'b0;
      PROJ_TRG    <= 1'b0;
      MASK_EN     <= 1'b0;
      PIXGLOB_RES <= 1'b0;
      PIXVTG_GLOB <= 1'b0;
      PIXDRAIN    <= 1'b1;
      PIXGSUBC    <= 1'b0;
      contrastLED <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values.
      state       <= nxt;
      cnt         <= nxt_cnt;
      row         <= nxt_row;
      pat         <= nxt_pat;
      rep         <= nxt_rep;
      gsub_n      <= nxt_gsub;
      if (frame_start) cfg_q <= cfg_live;
      trigger_o   <= o_trig;
      ROWADD      <= o_rowadd;
      EN_STREAM   <= o_en_stream;
      DES_2ND     <= o_des;
      PROJ_TRG    <= o_proj;
      MASK_EN     <= o_mask;
      PIXGLOB_RES <= o_gres;
      PIXVTG_GLOB <= o_vtg;
      PIXDRAIN    <= o_drain;
      PIXGSUBC    <= o_gsubc;
      contrastLED <= o_led;
    end
  end

endmodule

// File: tb/tb_exposure_v1_t7.sv
// Scoreboard bench for exposure_v1_t7: stimulus queues expected event timings,
// a negedge monitor pops and compares them as the DUT produces each event.
module tb_exposure_v1_t7;

  logic        CLKM = 1'b0;
  logic        rst = 1'b0;
  logic        re_busy = 1'b0;
  logic [31:0] NUM_PAT, NUM_REP, NUM_ROW, NUM_GSUB;
  logic [31:0] Tproj_dly, Tgl_res, Treset, Tadd, Texp_ctrl, Tdes2_d, Tdes2_w;
  logic [31:0] Tmsken_d, Tmsken_w, Tgsub_w, TdrainR_d, TdrainF_d;
  logic        trigger_o, EN_STREAM, DES_2ND, PROJ_TRG, MASK_EN;
  logic        PIXGLOB_RES, PIXVTG_GLOB, PIXDRAIN, PIXGSUBC, contrastLED;
  logic [7:0]  ROWADD;

  exposure_v1_t7 dut (
    .CLKM(CLKM), .rst(rst), .re_busy(re_busy),
    .NUM_PAT(NUM_PAT), .NUM_REP(NUM_REP), .NUM_ROW(NUM_ROW), .NUM_GSUB(NUM_GSUB),
    .Tproj_dly(Tproj_dly), .Tgl_res(Tgl_res), .Treset(Treset), .Tadd(Tadd),
    .Texp_ctrl(Texp_ctrl), .Tdes2_d(Tdes2_d), .Tdes2_w(Tdes2_w),
    .Tmsken_d(Tmsken_d), .Tmsken_w(Tmsken_w), .Tgsub_w(Tgsub_w),
    .TdrainR_d(TdrainR_d), .TdrainF_d(TdrainF_d),
    .trigger_o(trigger_o), .ROWADD(ROWADD), .EN_STREAM(EN_STREAM), .DES_2ND(DES_2ND),
    .PROJ_TRG(PROJ_TRG), .MASK_EN(MASK_EN), .PIXGLOB_RES(PIXGLOB_RES),
    .PIXVTG_GLOB(PIXVTG_GLOB), .PIXDRAIN(PIXDRAIN), .PIXGSUBC(PIXGSUBC),
    .contrastLED(contrastLED)
  );

  always #5 CLKM = ~CLKM;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int trig_cnt = 0;
  logic mon_en = 1'b0;

  int proj_q[$], trig_q[$], row_q[$], des_q[$], msk_q[$], drn_q[$], gsub_q[$], gap_q[$];

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic flag_unexpected(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: event seen with nothing expected (got 1, expected 0)", name);
  endtask

  // Expected events for one frame; offsets are cycles after the first GRES cycle.
  task automatic push_frame(input int npat, input int nrow, input int proj_first,
                            input int pat_len, input int trig_off, input int des_len,
                            input int msk_len, input int drn_len, input int ngsub,
                            input int gsub_w);
    for (int p = 0; p < npat; p++) begin
      proj_q.push_back(proj_first + p * pat_len);
      for (int r = 0; r < nrow; r++) begin
        row_q.push_back(r);
        des_q.push_back(des_len);
      end
      msk_q.push_back(msk_len);
      drn_q.push_back(drn_len);
      for (int g = 0; g < ngsub; g++) gsub_q.push_back(gsub_w);
    end
    trig_q.push_back(trig_off);
  endtask

  function automatic int pending();
    return proj_q.size() + trig_q.size() + row_q.size() + des_q.size() +
           msk_q.size() + drn_q.size() + gsub_q.size() + gap_q.size();
  endfunction

  // Monitor: samples on the falling edge, well away from the active edge.
  logic p_gres = 1'b0, p_busy = 1'b0, p_des = 1'b0, p_msk = 1'b0, p_drn = 1'b1, p_gsub = 1'b0;
  int gres_cyc = 0, busy_fall_cyc = 0, des_st = 0, msk_st = 0, drn_st = 0, gsub_st = 0;

  always @(negedge CLKM) begin
    cyc++;
    if (PIXGLOB_RES && !p_gres) begin
      gres_cyc = cyc;
      if (mon_en && gap_q.size() != 0)
        check("gres_after_busy_fall", cyc - busy_fall_cyc, gap_q.pop_front());
    end
    if (!re_busy && p_busy) busy_fall_cyc = cyc;
    if (trigger_o) begin
      trig_cnt++;
      if (mon_en) begin
        check("no_trigger_while_busy", int'(re_busy), 0);
        if (trig_q.size() == 0) flag_unexpected("trigger_o");
        else check("trigger_offset", cyc - gres_cyc, trig_q.pop_front());
      end
    end
    if (mon_en && PROJ_TRG) begin
      if (proj_q.size() == 0) flag_unexpected("PROJ_TRG");
      else check("proj_trg_offset", cyc - gres_cyc, proj_q.pop_front());
    end
    if (mon_en && EN_STREAM) begin
      if (row_q.size() == 0) flag_unexpected("EN_STREAM");
      else check("rowadd_at_en_stream", int'(ROWADD), row_q.pop_front());
    end
    if (DES_2ND && !p_des) des_st = cyc;
    if (!DES_2ND && p_des && mon_en) begin
      if (des_q.size() == 0) flag_unexpected("DES_2ND");
      else check("des_2nd_width", cyc - des_st, des_q.pop_front());
    end
    if (MASK_EN && !p_msk) msk_st = cyc;
    if (!MASK_EN && p_msk && mon_en) begin
      if (msk_q.size() == 0) flag_unexpected("MASK_EN");
      else check("mask_en_width", cyc - msk_st, msk_q.pop_front());
    end
    if (!PIXDRAIN && p_drn) drn_st = cyc;
    if (PIXDRAIN && !p_drn && mon_en) begin
      if (drn_q.size() == 0) flag_unexpected("PIXDRAIN_low");
      else check("pixdrain_low_width", cyc - drn_st, drn_q.pop_front());
    end
    if (PIXGSUBC && !p_gsub) gsub_st = cyc;
    if (!PIXGSUBC && p_gsub && mon_en) begin
      if (gsub_q.size() == 0) flag_unexpected("PIXGSUBC");
      else check("pixgsubc_width", cyc - gsub_st, gsub_q.pop_front());
    end
    p_gres = PIXGLOB_RES; p_busy = re_busy; p_des = DES_2ND;
    p_msk = MASK_EN; p_drn = PIXDRAIN; p_gsub = PIXGSUBC;
  end

  function automatic int out_bits();
    return int'({trigger_o, EN_STREAM, DES_2ND, PROJ_TRG, MASK_EN, PIXGLOB_RES,
                 PIXVTG_GLOB, PIXDRAIN, PIXGSUBC, contrastLED});
  endfunction

  task automatic wait_trig(input string name, input int budget);
    int start;
    start = trig_cnt;
    for (int i = 0; i < budget && trig_cnt == start; i++) @(posedge CLKM);
    check({name, "_trigger_seen"}, int'(trig_cnt != start), 1);
    repeat (5) @(posedge CLKM);
    check({name, "_all_events_seen"}, pending(), 0);
  endtask

  task automatic cfg_base();
    NUM_PAT = 4; NUM_REP = 2; NUM_ROW = 10; NUM_GSUB = 0;
    Tgl_res = 200; Treset = 100; Tproj_dly = 110; Tadd = 3; Tdes2_d = 2; Tdes2_w = 4;
    Texp_ctrl = 159; TdrainR_d = 10; TdrainF_d = 100; Tmsken_d = 4; Tmsken_w = 11;
    Tgsub_w = 100;
  endtask

  task automatic release_rst();
    @(posedge CLKM);
    #1 rst = 1'b0;
  endtask

  task automatic apply_rst();
    @(posedge CLKM);
    #1 rst = 1'b1;
    repeat (2) @(posedge CLKM);
  endtask

  initial begin
    int found;
    cfg_base();
    // Reset state: outputs must go to reset values as soon as rst rises.
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", out_bits(), 32'h004);
    check("reset_rowadd", int'(ROWADD), 0);

    // Baseline frame: 8 patterns of 369 cycles after 300 cycles of GRES+SETTLE.
    repeat (3) @(posedge CLKM);
    push_frame(8, 10, 300, 369, 3252, 4, 11, 69, 0, 100);
    mon_en = 1'b1;
    release_rst();
    wait_trig("frame_base", 4000);

    // Readout handshake: busy for 500 cycles, then next frame one cycle after it drops.
    push_frame(8, 10, 300, 369, 3252, 4, 11, 69, 0, 100);
    gap_q.push_back(1);
    @(posedge CLKM);
    #1 re_busy = 1'b1;
    repeat (500) @(posedge CLKM);
    #1 re_busy = 1'b0;
    wait_trig("frame_after_busy", 5000);

    // Two GSUB pulses of 100 cycles add 400 cycles per pattern.
    apply_rst();
    NUM_GSUB = 2;
    push_frame(8, 10, 300, 769, 6452, 4, 11, 69, 2, 100);
    release_rst();
    wait_trig("frame_gsub", 7000);

    // Short frame: SETTLE and DRAIN skipped, PROJ held to one cycle; abort it in ROWLD.
    apply_rst();
    mon_en = 1'b0;
    NUM_PAT = 1; NUM_REP = 1; NUM_ROW = 3; NUM_GSUB = 1; Tgl_res = 2; Treset = 0;
    Tproj_dly = 0; Tadd = 1; Tdes2_d = 1; Tdes2_w = 2; Texp_ctrl = 5; TdrainR_d = 0;
    TdrainF_d = 0; Tmsken_d = 0; Tmsken_w = 2; Tgsub_w = 3;
    release_rst();
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge CLKM);
      if (EN_STREAM && ROWADD == 8'd1) found = 1;
    end
    check("reached_rowld_row1", found, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_outputs", out_bits(), 32'h004);
    check("abort_rowadd", int'(ROWADD), 0);
    repeat (3) @(posedge CLKM);
    push_frame(1, 3, 2, 0, 26, 2, 2, 5, 1, 3);
    mon_en = 1'b1;
    release_rst();
    wait_trig("frame_short_restart", 200);

    // No mask rows: EXP directly after PROJ, MASK_EN window clipped to 18 cycles.
    apply_rst();
    NUM_PAT = 2; NUM_REP = 1; NUM_ROW = 0; NUM_GSUB = 0; Tgl_res = 5; Treset = 3;
    Tproj_dly = 7; Texp_ctrl = 20; TdrainR_d = 4; TdrainF_d = 10; Tmsken_d = 2; Tmsken_w = 30;
    push_frame(2, 0, 8, 31, 70, 0, 18, 14, 0, 0);
    release_rst();
    wait_trig("frame_no_rows", 300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
